// File: rtl/asic_io_pkg.sv
// Shared types and constants for the board-I/O front end.
package asic_io_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t        SEG_BLANK  = 8'h00;
    localparam int unsigned PWM_LEVELS = 16;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/asic_io_shell_key_debounce.sv
// One key: 2-flop synchroniser, hold-time debounce counter and press pulse.
module key_debounce
    import asic_io_pkg::*;
#(
    parameter int unsigned debounce_cycles = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_db,
    output logic key_press
);

    localparam int unsigned    CW       = cnt_w(debounce_cycles);
    localparam logic [CW-1:0]  CNT_LAST = CW'(debounce_cycles - 1);

    logic          meta;
    logic          ksync;
    logic [CW-1:0] cnt;

    // Any cycle where ksync agrees with key_db restarts the hold count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta      <= 1'b0;
            ksync     <= 1'b0;
            cnt       <= '0;
            key_db    <= 1'b0;
            key_press <= 1'b0;
        end else begin
            meta      <= key_raw;
            ksync     <= meta;
            key_press <= 1'b0;
            if (ksync == key_db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                key_db    <= ksync;
                key_press <= ksync;
                cnt       <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/asic_io_shell.sv
// Board-I/O front end: debounced keys and a PWM-dimmed, dead-timed digit scanner.
module asic_io_shell
    import asic_io_pkg::*;
#(
    parameter int unsigned clk_mhz         = 50,
    parameter int unsigned w_key           = 4,
    parameter int unsigned w_digit         = 8,
    parameter int unsigned digit_cycles    = clk_mhz * 1000,
    parameter int unsigned debounce_cycles = clk_mhz * 10000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [w_key-1:0]       key_raw,
    output logic [w_key-1:0]       key_db,
    output logic [w_key-1:0]       key_press,
    input  logic [w_digit*8-1:0]   seg_data,
    input  logic [w_digit-1:0]     digit_en,
    input  logic [3:0]             brightness,
    output logic [7:0]             abcdefgh,
    output logic [w_digit-1:0]     digit
);

    localparam int unsigned SW   = cnt_w(digit_cycles);
    localparam int unsigned IW   = cnt_w(w_digit);
    localparam int unsigned TW   = SW + 1;
    localparam int unsigned DW   = w_digit;
    localparam int unsigned STEP = digit_cycles / PWM_LEVELS;

    for (genvar k = 0; k < w_key; k++) begin : g_key
        key_debounce #(.debounce_cycles(debounce_cycles)) u_key (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_raw   (key_raw[k]),
            .key_db    (key_db[k]),
            .key_press (key_press[k])
        );
    end

    logic [SW-1:0] slot_cnt;
    logic [IW-1:0] idx;
    seg_t          seg_q;
    logic          en_q;
    logic [3:0]    bright_q;

    seg_t          seg_sel_c;
    logic          en_sel_c;
    logic [TW-1:0] thr_c;
    logic          lit_c;
    logic [DW-1:0] onehot_c;

    // Current digit's inputs, PWM threshold and lit decision.
    always_comb begin
        seg_sel_c = SEG_BLANK;
        en_sel_c  = 1'b0;
        for (int i = 0; i < int'(w_digit); i++) begin
            if (idx == IW'(i)) begin
                seg_sel_c = seg_data[8*i +: 8];
                en_sel_c  = digit_en[i];
            end
        end
        thr_c    = (TW'(bright_q) + TW'(1)) * TW'(STEP);
        lit_c    = en_q && (slot_cnt != '0) && (TW'(slot_cnt) < thr_c);
        onehot_c = DW'(1) << idx;
    end

    // Slot/digit counters, slot-start snapshot and registered drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            idx      <= '0;
            seg_q    <= SEG_BLANK;
            en_q     <= 1'b0;
            bright_q <= '0;
            digit    <= '0;
            abcdefgh <= SEG_BLANK;
        end else begin
            if (slot_cnt == SW'(digit_cycles - 1)) begin
                slot_cnt <= '0;
                idx      <= (idx == IW'(w_digit - 1)) ? '0 : idx + IW'(1);
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end
            if (slot_cnt == '0) begin
                seg_q    <= seg_sel_c;
                en_q     <= en_sel_c;
                bright_q <= brightness;
            end
            digit    <= lit_c ? onehot_c : '0;
            abcdefgh <= lit_c ? seg_q : SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_asic_io_shell.sv
// Randomised self-checking bench for asic_io_shell against a cycle-indexed reference model.
module tb_asic_io_shell;

    localparam int unsigned NK = 2;
    localparam int unsigned ND = 4;
    localparam int unsigned DC = 32;
    localparam int unsigned DB = 4;
    localparam int FRAME = int'(DC * ND);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NK-1:0]   key_raw = '0;
    logic [NK-1:0]   key_db;
    logic [NK-1:0]   key_press;
    logic [ND*8-1:0] seg_data = '0;
    logic [ND-1:0]   digit_en = '0;
    logic [3:0]      brightness = '0;
    logic [7:0]      abcdefgh;
    logic [ND-1:0]   digit;

    asic_io_shell #(
        .clk_mhz(1), .w_key(NK), .w_digit(ND),
        .digit_cycles(DC), .debounce_cycles(DB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .key_db(key_db),
        .key_press(key_press), .seg_data(seg_data), .digit_en(digit_en),
        .brightness(brightness), .abcdefgh(abcdefgh), .digit(digit)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: key history windows and scan position from edge count.
    logic [5:0]    hist [NK];
    logic [NK-1:0] m_db, m_press;
    int            e;
    logic [7:0]    snap_seg;
    logic          snap_en;
    int            snap_br;
    logic [ND-1:0] m_digit;
    logic [7:0]    m_seg;
    int            litc [ND];

    task automatic model_reset();
        for (int k = 0; k < int'(NK); k++) hist[k] = '0;
        m_db = '0; m_press = '0; e = 0;
        snap_seg = '0; snap_en = 1'b0; snap_br = 0;
        m_digit = '0; m_seg = '0;
    endtask

    task automatic step();
        int sc, ix;
        bit lit;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            // A key level is accepted once the last DB synchronised samples all disagree with it.
            for (int k = 0; k < int'(NK); k++) begin
                hist[k] = {hist[k][4:0], key_raw[k]};
                m_press[k] = 1'b0;
                if (hist[k][5:2] == {4{~m_db[k]}}) begin
                    m_db[k]    = ~m_db[k];
                    m_press[k] = m_db[k];
                end
            end
            sc = e % int'(DC);
            ix = (e / int'(DC)) % int'(ND);
            if (sc == 0) begin
                snap_seg = seg_data[ix*8 +: 8];
                snap_en  = digit_en[ix];
                snap_br  = int'(brightness);
            end
            lit = snap_en && (sc >= 1) && (sc < (snap_br + 1) * int'(DC / 16));
            m_digit = lit ? ND'(1 << ix) : '0;
            m_seg   = lit ? snap_seg : 8'h00;
            e++;
        end
        @(negedge clk);
        check("key_db", 32'(key_db), 32'(m_db));
        check("key_press", 32'(key_press), 32'(m_press));
        check("digit", 32'(digit), 32'(m_digit));
        check("abcdefgh", 32'(abcdefgh), 32'(m_seg));
        for (int i = 0; i < int'(ND); i++) if (digit == ND'(1 << i)) litc[i]++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until the next edge starts digit 0 of a new frame.
    task automatic align();
        for (int i = 0; i < FRAME && (e % FRAME) != 0; i++) step();
    endtask

    task automatic frame_count();
        for (int i = 0; i < int'(ND); i++) litc[i] = 0;
        steps(FRAME);
    endtask

    initial begin
        int n, cnt;
        logic [ND-1:0] prev;
        logic [ND-1:0] seq [$];

        model_reset();
        @(negedge clk);
        // Reset held with inputs toggling.
        for (int i = 0; i < 6; i++) begin
            key_raw    = NK'($urandom);
            seg_data   = $urandom;
            digit_en   = ND'($urandom);
            brightness = 4'($urandom);
            step();
        end
        key_raw = '0; seg_data = 32'h44332211; digit_en = 4'hF; brightness = 4'd15;
        rst_n = 1'b1;
        n = 0;
        do begin step(); n++; end while (digit == '0 && n < 10);
        check("first_lit_cycle", 32'(n), 32'd2);
        check("first_digit", 32'(digit), 32'h1);

        // Scan order and full-brightness duty.
        align();
        prev = '0;
        for (int i = 0; i < int'(ND); i++) litc[i] = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (digit != '0 && digit != prev) begin
                seq.push_back(digit);
                if (seq.size() == 1) check("seg_first", 32'(abcdefgh), 32'h11);
            end
            if (digit != '0) prev = digit;
        end
        check("scan_len", 32'(seq.size()), 32'd4);
        for (int i = 0; i < seq.size() && i < int'(ND); i++)
            check("scan_order", 32'(seq[i]), 32'(1 << i));
        for (int i = 0; i < int'(ND); i++) check("lit_b15", 32'(litc[i]), 32'd31);
        steps(2);
        check("scan_wrap", 32'(digit), 32'h1);

        // Clean press, latency and one-cycle pulse.
        key_raw[0] = 1'b1;
        n = 0;
        do begin step(); n++; end while (!key_db[0] && n < 20);
        check("press_latency", 32'(n), 32'd6);
        check("press_pulse", 32'(key_press[0]), 32'd1);
        step();
        check("press_one_cycle", 32'(key_press[0]), 32'd0);

        // Short glitch must be filtered.
        key_raw[1] = 1'b1;
        steps(3);
        key_raw[1] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin step(); cnt += int'(key_press[1]); end
        check("glitch_db", 32'(key_db[1]), 32'd0);
        check("glitch_press", 32'(cnt), 32'd0);

        // Release gives no pulse.
        key_raw[0] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin step(); cnt += int'(key_press[0]); end
        check("release_db", 32'(key_db[0]), 32'd0);
        check("release_press", 32'(cnt), 32'd0);

        // Random keys and display inputs against the model.
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < int'(NK); k++)
                if ($urandom_range(7) == 0) key_raw[k] = ~key_raw[k];
            if ($urandom_range(15) == 0) begin
                seg_data   = $urandom;
                digit_en   = ND'($urandom);
                brightness = 4'($urandom);
            end
            step();
        end
        key_raw = '0;

        // Blanking and minimum / mid brightness.
        seg_data = 32'h44332211; digit_en = 4'b1011; brightness = 4'd0;
        align();
        frame_count();
        check("b0_d0", 32'(litc[0]), 32'd1);
        check("b0_d1", 32'(litc[1]), 32'd1);
        check("b0_d2_blank", 32'(litc[2]), 32'd0);
        check("b0_d3", 32'(litc[3]), 32'd1);
        brightness = 4'd7;
        align();
        frame_count();
        check("b7_d0", 32'(litc[0]), 32'd15);
        check("b7_d2_blank", 32'(litc[2]), 32'd0);
        check("b7_d3", 32'(litc[3]), 32'd15);

        // Mid-slot change only lands on the next digit-0 slot.
        digit_en = 4'hF; brightness = 4'd15;
        align();
        steps(10);
        seg_data[7:0] = 8'h5A;
        cnt = 0;
        for (int i = 0; i < int'(DC) - 10; i++) begin
            step();
            if (digit == 4'h1 && abcdefgh == 8'h11) cnt++;
        end
        check("no_tearing", 32'(cnt), 32'd22);
        align();
        steps(2);
        check("update_next_slot", 32'(abcdefgh), 32'h5A);

        // Asynchronous reset while digit 2 is lit.
        n = 0;
        while (digit != 4'b0100 && n < FRAME) begin step(); n++; end
        check("reach_digit2", 32'(digit), 32'h4);
        rst_n = 1'b0;
        #1;
        check("async_digit", 32'(digit), 32'd0);
        check("async_seg", 32'(abcdefgh), 32'd0);
        model_reset();
        @(negedge clk);
        steps(2);
        rst_n = 1'b1;
        n = 0;
        do begin step(); n++; end while (digit == '0 && n < 10);
        check("restart_cycle", 32'(n), 32'd2);
        check("restart_digit", 32'(digit), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/asic_io_shell.md
Name: asic_io_shell

Overview:
- Parametrised board-I/O front end between the raw ASIC pins and `lab_top`.
- Synchronises and debounces `w_key` raw keys and emits one-cycle press pulses.
- Drives a dynamic `w_digit` seven-segment display with per-digit blanking, 16-level PWM brightness and anti-ghosting dead time.
- Replaces the direct pin-to-lab wiring used so far.

Parameters:
- clk_mhz, 50: core clock frequency; used only for defaults.
- w_key, 4: number of keys.
- w_digit, 8: number of display digits; must be ≥ 1.
- digit_cycles, clk_mhz*1000: clock cycles per digit slot; must be a multiple of 16 and ≥ 32.
- debounce_cycles, clk_mhz*10000: cycles a key must hold its new level before it is accepted; must be ≥ 2.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- key_raw  in  w_key  raw key pins (active high, asynchronous)
- key_db  out  w_key  debounced key levels
- key_press  out  w_key  one-cycle pulse on each debounced 0→1 transition
- seg_data  in  w_digit*8  abcdefgh pattern per digit; digit i occupies bits [8i+7:8i]
- digit_en  in  w_digit  per-digit enable; 0 blanks that digit
- brightness  in  4  PWM level, 0 = dimmest, 15 = full
- abcdefgh  out  8  segment drive, active high
- digit  out  w_digit  one-hot digit select, active high

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n = 0, every register clears, so key_db, key_press, abcdefgh and digit are all 0. The first active edge after release starts slot 0, digit 0.
- Key path, per key:
  - 2-flop synchroniser (reset 0) produces ksync.
  - Counter cnt, width $clog2(debounce_cycles).
  - If ksync == key_db: cnt <= 0.
  - Otherwise cnt increments. When cnt == debounce_cycles-1: key_db <= ksync and cnt <= 0; key_press pulses for exactly that one cycle if ksync == 1.
- Key path properties:
  - A glitch shorter than debounce_cycles resets the count and never reaches key_db.
  - Latency from a clean pin edge to key_db is 2 + debounce_cycles cycles.
  - A key release produces no pulse.
  - Keys are fully independent; simultaneous presses give simultaneous pulses.
- Scanner:
  - slot_cnt runs 0..digit_cycles-1. idx runs 0..w_digit-1 and advances when slot_cnt wraps; idx wraps from w_digit-1 to 0. If w_digit = 1, idx stays 0.
  - At slot_cnt == 0 (slot start), snapshot seg_data[idx], digit_en[idx] and brightness into slot registers. Input changes mid-slot take effect only at the next slot, so there is no tearing.
  - thr = (bright_q+1)*(digit_cycles/16).
  - lit = en_q && (slot_cnt >= 1) && (slot_cnt < thr). Slot cycle 0 is always dark: this is the dead time.
  - Outputs are registered, one cycle after the counter state: digit <= lit ? (1<<idx) : 0 and abcdefgh <= lit ? seg_q : 0.
  - digit is never multi-hot. abcdefgh is 0 whenever digit is 0.
- Brightness: brightness = 15 gives digit_cycles-1 lit cycles per slot; brightness = 0 gives digit_cycles/16 - 1 lit cycles.
- Reset mid-scan: outputs go to 0 immediately and asynchronously. Scanning restarts at digit 0.
- Arithmetic: thr is computed at width $clog2(digit_cycles)+1 so it does not overflow when bright_q = 15.

Decomposition:
- Package asic_io_pkg:
  - typedef seg_t (logic [7:0]).
  - Localparam helpers for counter widths.
  - Constants SEG_BLANK = 8'h00 and PWM_LEVELS = 16.
- Sub-module key_debounce (synchroniser + counter + pulse for one key), instantiated w_key times in a generate loop. The scanner stays inline.

Test Plan (bench parameters: w_key = 2, w_digit = 4, digit_cycles = 32, debounce_cycles = 4):
- Reset: hold rst_n = 0 with all inputs toggling → key_db = 0, key_press = 0, digit = 0, abcdefgh = 0. After release, the first lit output is digit = 4'b0001 at slot cycle 2, counted from release (dead time plus output register).
- Clean press: key_raw[0] rises and holds → key_db[0] = 1 exactly 6 cycles later. key_press[0] is high for exactly that one cycle. key_raw[1] pulsed for 3 cycles → key_db[1] stays 0 and there is no pulse.
- Scan order: seg_data = {8'h44, 8'h33, 8'h22, 8'h11}, digit_en = 4'hF, brightness = 15 → digit sequence 0001, 0010, 0100, 1000, 0001 with abcdefgh 11, 22, 33, 44. Each digit has 31 lit cycles and 1 dark cycle per slot.
- Blanking and PWM: digit_en = 4'b1011, brightness = 0 → digit 2 is never lit. The other digits are lit for exactly 1 cycle per slot (slot_cnt 1). With brightness = 7 they are lit for 15 cycles.
- Mid-slot update: change seg_data[7:0] from 11 to 5A at slot_cnt = 10 of digit 0 → abcdefgh stays 11 for the rest of that slot and shows 5A in the next digit-0 slot.
- Reset mid-scan: assert rst_n = 0 while digit = 0100 → digit = 0 and abcdefgh = 0 in the same cycle, asynchronously. After release the scan restarts at 0001.
